// File: rtl/calc_entry_ctrl.sv
// Key-entry sequencer for the keypad calculator: builds BCD operands and an operator,
// starts the arithmetic unit and presents its result. Optional macro MEMORY_KEYS_EN adds F1-F3 memory keys.
module calc_entry_ctrl #(
    parameter int P_DIGITS  = 4,
    parameter int P_TIMEOUT = 1023
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_key_valid,
    input  logic [4:0]            i_bcd_data,
    input  logic                  i_alu_done,
    input  logic                  i_alu_err,
    input  logic                  i_alu_neg,
    input  logic [4*P_DIGITS-1:0] i_alu_result,
    output logic                  o_alu_start,
    output logic [4*P_DIGITS-1:0] o_alu_a,
    output logic [4*P_DIGITS-1:0] o_alu_b,
    output logic [1:0]            o_alu_op,
    output logic [4*P_DIGITS-1:0] o_disp_bcd,
    output logic                  o_disp_neg,
    output logic                  o_err,
    output logic                  o_busy,
    output logic [2:0]            o_state
);

    localparam int W  = 4 * P_DIGITS;
    localparam int CW = $clog2(P_DIGITS + 1);
    localparam int TW = $clog2(P_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_WAIT = 3'd2,
        S_RES  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Strobe semantics: i_key_valid and i_alu_done are single-cycle qualifiers with no
    // back-pressure; data is consumed in exactly the cycle its strobe is high.
    state_t         state_q, state_d;
    logic [W-1:0]   work_q, work_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   disp_q, disp_d;
    logic           neg_q, neg_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           start_q, start_d;

    logic           key_digit;
    logic           key_op;
    logic           key_ent;
    logic           key_esc;
    logic [1:0]     key_op_code;
    logic [W-1:0]   key_val;
    logic [W-1:0]   work_shift;

    assign key_digit   = i_key_valid && (i_bcd_data <= 5'h09);
    assign key_op      = i_key_valid && (i_bcd_data[4:2] == 3'b100);
    assign key_ent     = i_key_valid && (i_bcd_data == 5'h15);
    assign key_esc     = i_key_valid && (i_bcd_data == 5'h14);
    // % X - + sit at 0x10..0x13 and encode as 11 10 01 00
    assign key_op_code = ~i_bcd_data[1:0];
    assign key_val     = W'(i_bcd_data[3:0]);
    assign work_shift  = (work_q << 4) | key_val;

`ifdef MEMORY_KEYS_EN
    logic [W-1:0]   mem_q, mem_d;
    logic           key_f1;
    logic           key_f2;
    logic           key_f3;

    assign key_f1 = i_key_valid && (i_bcd_data == 5'h19);
    assign key_f2 = i_key_valid && (i_bcd_data == 5'h18);
    assign key_f3 = i_key_valid && (i_bcd_data == 5'h17);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_A;
            work_q  <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            disp_q  <= '0;
            neg_q   <= 1'b0;
            tmo_q   <= '0;
            start_q <= 1'b0;
`ifdef MEMORY_KEYS_EN
            mem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            disp_q  <= disp_d;
            neg_q   <= neg_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
`ifdef MEMORY_KEYS_EN
            mem_q   <= mem_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        disp_d  = disp_q;
        neg_d   = neg_q;
        tmo_d   = tmo_q;
        start_d = 1'b0;
`ifdef MEMORY_KEYS_EN
        mem_d   = mem_q;
`endif
        // Esc returns to the reset state from anywhere and outranks a same-cycle done
        if (key_esc) begin
            state_d = S_A;
            work_d  = '0;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = '0;
            op_d    = 2'b00;
            disp_d  = '0;
            neg_d   = 1'b0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                S_A, S_B: begin
                    if (key_digit) begin
                        if (cnt_q < CW'(P_DIGITS)) begin
                            work_d = work_shift;
                            cnt_d  = cnt_q + 1'b1;
                            disp_d = work_shift;
                        end
                    end else if (key_op) begin
                        op_d = key_op_code;
                        if (state_q == S_A) begin
                            a_d     = work_q;
                            work_d  = '0;
                            cnt_d   = '0;
                            disp_d  = work_q;
                            state_d = S_B;
                        end
                    end else if (key_ent && (state_q == S_B)) begin
                        b_d     = work_q;
                        start_d = 1'b1;
                        tmo_d   = '0;
                        state_d = S_WAIT;
                    end
`ifdef MEMORY_KEYS_EN
                    else if (key_f2) begin
                        work_d = mem_q;
                        cnt_d  = CW'(P_DIGITS);
                        disp_d = mem_q;
                    end
`endif
                end
                S_WAIT: begin
                    if (i_alu_done && !i_alu_err) begin
                        disp_d  = i_alu_result;
                        neg_d   = i_alu_neg;
                        state_d = S_RES;
                    end else if (i_alu_done) begin
                        disp_d  = '0;
                        neg_d   = 1'b0;
                        state_d = S_ERR;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                        if (tmo_q == TW'(P_TIMEOUT - 1)) begin
                            disp_d  = '0;
                            neg_d   = 1'b0;
                            state_d = S_ERR;
                        end
                    end
                end
                S_RES: begin
                    if (key_digit) begin
                        work_d  = key_val;
                        cnt_d   = CW'(1);
                        disp_d  = key_val;
                        neg_d   = 1'b0;
                        state_d = S_A;
                    end else if (key_op && !neg_q) begin
                        // chaining: the shown result becomes operand A
                        a_d     = disp_q;
                        op_d    = key_op_code;
                        work_d  = '0;
                        cnt_d   = '0;
                        state_d = S_B;
                    end
`ifdef MEMORY_KEYS_EN
                    else if (key_f2) begin
                        work_d  = mem_q;
                        cnt_d   = CW'(P_DIGITS);
                        disp_d  = mem_q;
                        neg_d   = 1'b0;
                        state_d = S_A;
                    end
`endif
                end
                S_ERR: begin
                    disp_d = '0;
                    neg_d  = 1'b0;
                end
                default: state_d = S_A;
            endcase
`ifdef MEMORY_KEYS_EN
            if ((state_q == S_A) || (state_q == S_B) || (state_q == S_RES)) begin
                if (key_f1) mem_d = disp_q;
                if (key_f3) mem_d = '0;
            end
`endif
        end
    end

    assign o_alu_start = start_q;
    assign o_alu_a     = a_q;
    assign o_alu_b     = b_q;
    assign o_alu_op    = op_q;
    assign o_disp_bcd  = disp_q;
    assign o_disp_neg  = neg_q;
    assign o_err       = (state_q == S_ERR);
    assign o_busy      = (state_q == S_WAIT);
    assign o_state     = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: decimal-value model checked every cycle plus directed literal checks.
// Honors MEMORY_KEYS_EN when it is defined for the build.
module tb_calc_entry_ctrl;

    localparam int P_DIGITS  = 4;
    localparam int P_TIMEOUT = 20;
    localparam int W         = 4 * P_DIGITS;

    localparam logic [4:0] K_PCT = 5'h10, K_MUL = 5'h11, K_SUB = 5'h12, K_ADD = 5'h13;
    localparam logic [4:0] K_ESC = 5'h14, K_ENT = 5'h15;
    localparam logic [4:0] K_F3 = 5'h17, K_F2 = 5'h18, K_F1 = 5'h19;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_key_valid = 1'b0;
    logic [4:0]    i_bcd_data = 5'h0F;
    logic          i_alu_done = 1'b0;
    logic          i_alu_err = 1'b0;
    logic          i_alu_neg = 1'b0;
    logic [W-1:0]  i_alu_result = '0;
    logic          o_alu_start;
    logic [W-1:0]  o_alu_a;
    logic [W-1:0]  o_alu_b;
    logic [1:0]    o_alu_op;
    logic [W-1:0]  o_disp_bcd;
    logic          o_disp_neg;
    logic          o_err;
    logic          o_busy;
    logic [2:0]    o_state;

    calc_entry_ctrl #(.P_DIGITS(P_DIGITS), .P_TIMEOUT(P_TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_key_valid(i_key_valid), .i_bcd_data(i_bcd_data),
        .i_alu_done(i_alu_done), .i_alu_err(i_alu_err), .i_alu_neg(i_alu_neg),
        .i_alu_result(i_alu_result), .o_alu_start(o_alu_start), .o_alu_a(o_alu_a),
        .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_disp_bcd(o_disp_bcd),
        .o_disp_neg(o_disp_neg), .o_err(o_err), .o_busy(o_busy), .o_state(o_state)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < P_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] b);
        int r = 0;
        for (int i = P_DIGITS - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    // Model: operands held as decimal integers, modes named by role
    localparam int M_A = 0, M_B = 1, M_WAIT = 2, M_RES = 3, M_ERR = 4;
    int m_mode, m_work, m_ndig, m_a, m_b, m_disp, m_waited, m_mem;
    bit m_neg, m_start;
    logic [1:0] m_op;

    function automatic logic [1:0] op_of(input logic [4:0] c);
        case (c)
            K_ADD:   return 2'b00;
            K_SUB:   return 2'b01;
            K_MUL:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic m_clear();
        m_mode = M_A; m_work = 0; m_ndig = 0; m_a = 0; m_b = 0;
        m_op = 2'b00; m_disp = 0; m_neg = 1'b0; m_waited = 0;
    endtask

    task automatic m_key(input logic [4:0] c);
        if (c <= 5'h09) begin
            if (m_mode == M_RES) begin
                m_work = int'(c); m_ndig = 1; m_disp = m_work; m_neg = 1'b0; m_mode = M_A;
            end else if (m_ndig < P_DIGITS) begin
                m_work = m_work * 10 + int'(c); m_ndig++; m_disp = m_work;
            end
        end else if (c >= K_PCT && c <= K_ADD) begin
            if (m_mode == M_A) begin
                m_a = m_work; m_op = op_of(c); m_work = 0; m_ndig = 0; m_disp = m_a; m_mode = M_B;
            end else if (m_mode == M_B) begin
                m_op = op_of(c);
            end else if (!m_neg) begin
                m_a = m_disp; m_op = op_of(c); m_work = 0; m_ndig = 0; m_mode = M_B;
            end
        end else if (c == K_ENT && m_mode == M_B) begin
            m_b = m_work; m_start = 1'b1; m_waited = 0; m_mode = M_WAIT;
            exp_q.push_back(to_bcd(m_a));
        end
`ifdef MEMORY_KEYS_EN
        else if (c == K_F1) m_mem = m_disp;
        else if (c == K_F3) m_mem = 0;
        else if (c == K_F2) begin
            m_work = m_mem; m_ndig = P_DIGITS; m_disp = m_mem;
            if (m_mode == M_RES) begin m_neg = 1'b0; m_mode = M_A; end
        end
`endif
    endtask

    always @(posedge i_clk) begin
        m_start = 1'b0;
        if (i_rst) begin
            m_clear(); m_mem = 0;
        end else if (i_key_valid && i_bcd_data == K_ESC) begin
            m_clear();
        end else if (m_mode == M_WAIT) begin
            if (i_alu_done && !i_alu_err) begin
                m_mode = M_RES; m_disp = from_bcd(i_alu_result); m_neg = i_alu_neg;
            end else if (i_alu_done) begin
                m_mode = M_ERR; m_disp = 0; m_neg = 1'b0;
            end else begin
                m_waited++;
                if (m_waited == P_TIMEOUT) begin m_mode = M_ERR; m_disp = 0; m_neg = 1'b0; end
            end
        end else if (m_mode != M_ERR && i_key_valid) begin
            m_key(i_bcd_data);
        end
    end

    // scoreboard: every cycle against the model, start pulses against the expected queue
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("alu_a", 32'(o_alu_a), 32'(to_bcd(m_a)));
            check("alu_b", 32'(o_alu_b), 32'(to_bcd(m_b)));
            check("alu_op", 32'(o_alu_op), 32'(m_op));
            check("alu_start", 32'(o_alu_start), 32'(m_start));
            check("disp_bcd", 32'(o_disp_bcd), 32'(to_bcd(m_disp)));
            check("disp_neg", 32'(o_disp_neg), 32'(m_neg));
            check("err", 32'(o_err), 32'(m_mode == M_ERR));
            check("busy", 32'(o_busy), 32'(m_mode == M_WAIT));
            if (o_alu_start === 1'b1) begin
                check("start_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("start_a", 32'(o_alu_a), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic press(input logic [4:0] c);
        i_key_valid = 1'b1;
        i_bcd_data  = c;
        tick();
        i_key_valid = 1'b0;
        i_bcd_data  = 5'h0F;
    endtask

    task automatic alu_done(input logic [W-1:0] r, input logic n, input logic e);
        i_alu_done = 1'b1; i_alu_result = r; i_alu_neg = n; i_alu_err = e;
        tick();
        i_alu_done = 1'b0; i_alu_neg = 1'b0; i_alu_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        i_rst = 1'b0;
        chk_en = 1'b1;
        check("rst_disp", 32'(o_disp_bcd), 32'h0);
        check("rst_err", 32'(o_err), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_start", 32'(o_alu_start), 32'h0);
        check("rst_op", 32'(o_alu_op), 32'h0);

        // 12 + 34
        press(5'h01); press(5'h02);
        check("t1_disp12", 32'(o_disp_bcd), 32'h0012);
        press(K_ADD);
        check("t1_disp_a", 32'(o_disp_bcd), 32'h0012);
        press(5'h03);
        check("t1_disp3", 32'(o_disp_bcd), 32'h0003);
        press(5'h04); press(K_ENT);
        check("t1_start", 32'(o_alu_start), 32'h1);
        check("t1_a", 32'(o_alu_a), 32'h0012);
        check("t1_b", 32'(o_alu_b), 32'h0034);
        check("t1_op", 32'(o_alu_op), 32'h0);
        tick();
        check("t1_start_once", 32'(o_alu_start), 32'h0);
        alu_done(16'h0046, 1'b0, 1'b0);
        check("t1_result", 32'(o_disp_bcd), 32'h0046);
        check("t1_busy", 32'(o_busy), 32'h0);

        // chain from result, memory store/recall
        press(K_F1);
        press(K_ADD); press(5'h04); press(K_ENT);
        check("chain_a", 32'(o_alu_a), 32'h0046);
        check("chain_b", 32'(o_alu_b), 32'h0004);
        alu_done(16'h0050, 1'b0, 1'b0);
        press(K_ESC);
        check("esc_disp", 32'(o_disp_bcd), 32'h0);
        press(K_F2);
`ifdef MEMORY_KEYS_EN
        check("mem_recall", 32'(o_disp_bcd), 32'h0046);
`else
        check("fkey_ignored", 32'(o_disp_bcd), 32'h0);
`endif
        press(K_F3);
        press(K_ESC);

        // digit cap, multiply, Esc abort in wait
        press(5'h09); press(5'h08); press(5'h07); press(5'h06); press(5'h05);
        check("cap_disp", 32'(o_disp_bcd), 32'h9876);
        press(K_MUL); press(5'h02); press(K_ENT);
        check("mul_op", 32'(o_alu_op), 32'h2);
        check("mul_a", 32'(o_alu_a), 32'h9876);
        check("mul_b", 32'(o_alu_b), 32'h0002);
        tick();
        press(K_ESC);
        check("abort_busy", 32'(o_busy), 32'h0);
        tick(); tick();
        alu_done(16'h1234, 1'b0, 1'b0);
        check("late_done_disp", 32'(o_disp_bcd), 32'h0);
        check("late_done_err", 32'(o_err), 32'h0);

        // timeout
        press(5'h05); press(K_SUB); press(K_ENT);
        repeat (P_TIMEOUT - 1) tick();
        check("tmo_not_yet", 32'(o_err), 32'h0);
        tick();
        check("tmo_err", 32'(o_err), 32'h1);
        check("tmo_disp", 32'(o_disp_bcd), 32'h0);
        press(K_ESC);
        check("tmo_esc", 32'(o_err), 32'h0);

        // ALU error, keys ignored while in error
        press(5'h08); press(K_PCT); press(5'h00); press(K_ENT);
        check("pct_op", 32'(o_alu_op), 32'h3);
        tick();
        alu_done(16'h0000, 1'b0, 1'b1);
        check("alu_err", 32'(o_err), 32'h1);
        press(5'h03);
        check("err_hold", 32'(o_err), 32'h1);
        check("err_disp", 32'(o_disp_bcd), 32'h0);
        press(K_ESC);

        // Esc and done together
        press(5'h01); press(K_ADD); press(5'h01); press(K_ENT);
        tick();
        i_key_valid = 1'b1; i_bcd_data = K_ESC;
        i_alu_done = 1'b1; i_alu_result = 16'h0002;
        tick();
        i_key_valid = 1'b0; i_bcd_data = 5'h0F; i_alu_done = 1'b0;
        check("esc_wins_disp", 32'(o_disp_bcd), 32'h0);
        check("esc_wins_busy", 32'(o_busy), 32'h0);

        // negative result cannot chain; ignored inputs
        press(5'h02); press(K_SUB); press(5'h05); press(K_ENT);
        alu_done(16'h0003, 1'b1, 1'b0);
        check("neg_disp", 32'(o_disp_bcd), 32'h0003);
        check("neg_flag", 32'(o_disp_neg), 32'h1);
        press(K_ADD);
        check("neg_nochain", 32'(o_alu_a), 32'h0002);
        press(5'h07);
        check("new_a_disp", 32'(o_disp_bcd), 32'h0007);
        check("new_a_neg", 32'(o_disp_neg), 32'h0);
        press(K_ENT);
        check("ent_in_a", 32'(o_busy), 32'h0);
        press(5'h0A);
        i_bcd_data = 5'h03; tick(); i_bcd_data = 5'h0F;
        alu_done(16'h0999, 1'b0, 1'b0);
        check("ignored_disp", 32'(o_disp_bcd), 32'h0007);

        // reset in the middle of a wait
        press(K_ADD); press(5'h02); press(K_ENT);
        tick();
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        check("midrst_a", 32'(o_alu_a), 32'h0);
        check("midrst_busy", 32'(o_busy), 32'h0);
        tick();
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
